// File: rtl/cpu_fetch_pkg.sv
// Shared encodings and constants for the fetch stage: next-PC selects,
// fetch FSM states, the NOP word and the default halt opcode.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_JR     = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR           = 32'h0000_0000;
  localparam logic [5:0]  DEFAULT_HALT_OPCODE = 6'b111111;

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: sequential, branch, J-type jump and
// register jump. All arithmetic wraps modulo 2^32.
module next_pc_calc
  import cpu_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jump_target,
  input  logic [31:0] reg_target,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] branch_target;

  always_comb begin
    pc_plus4      = pc + 32'd4;
    // imm_ext counts words, so scale to bytes before adding
    branch_target = pc_plus4 + (imm_ext << 2);
    next_pc       = pc_plus4;
    case (pc_src)
      PCSRC_SEQ:    next_pc = pc_plus4;
      PCSRC_BRANCH: next_pc = branch_taken ? branch_target : pc_plus4;
      PCSRC_JUMP:   next_pc = {pc_plus4[31:28], jump_target, 2'b00};
      PCSRC_JR:     next_pc = reg_target;
      default:      next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch-control FSM (BOOT -> RUN -> HALT) in front of an
// asynchronous instruction ROM. Define PC_INSTR_COUNT_EN to add retired_count.
module pc_fetch_unit
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_BYTES   = 100,
  parameter logic [5:0]  HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] imm_ext,
  input  logic [25:0] jump_target,
  input  logic [31:0] reg_target,
  input  logic        halt_req,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic        rom_rd,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_out,
  output logic        fetch_valid,
  output logic        halted,
`ifdef PC_INSTR_COUNT_EN
  output logic [31:0] retired_count,
`endif
  output logic        err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         err_q, err_d;
  logic [31:0]  next_pc;
  logic [32:0]  last_byte;
  logic         pc_legal;
  logic         halt_cond;
  logic         advance;

  next_pc_calc u_next_pc_calc (
    .pc           (pc_q),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .imm_ext      (imm_ext),
    .jump_target  (jump_target),
    .reg_target   (reg_target),
    .next_pc      (next_pc),
    .pc_plus4     (pc_plus4)
  );

  // 33-bit sum so the range test cannot be fooled by wrap-around
  assign last_byte = {1'b0, pc_q} + 33'd3;
  assign pc_legal  = (pc_q[1:0] == 2'b00) && (last_byte < 33'(MEM_BYTES));

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    err_d       = err_q;
    rom_rd      = 1'b1;
    fetch_valid = 1'b0;
    halted      = 1'b0;
    halt_cond   = 1'b0;
    advance     = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        rom_rd      = 1'b0;
        fetch_valid = pc_legal;
        halt_cond   = halt_req || (pc_legal && (instr_in[31:26] == HALT_OPCODE));
        if (!pc_legal) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else if (halt_cond) begin
          state_d = ST_HALT;
        end else if (!stall) begin
          pc_d    = next_pc;
          advance = 1'b1;
        end
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_BOOT;
    endcase
  end

  assign instr_out = fetch_valid ? instr_in : NOP_INSTR;
  assign pc        = pc_q;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

`ifdef PC_INSTR_COUNT_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (advance) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) retired_q <= 32'd0;
    else       retired_q <= retired_d;
  end

  assign retired_count = retired_q;
`endif

endmodule
